// File: rtl/jkff_sar_pkg.sv
// jkff_sar_pkg: JK opcode constants and next-state function shared by the JK bank
package jkff_sar_pkg;

    typedef logic [1:0] jk_t;

    localparam jk_t JK_HOLD = 2'b00;
    localparam jk_t JK_CLR  = 2'b01;
    localparam jk_t JK_SET  = 2'b10;
    localparam jk_t JK_TOG  = 2'b11;

    function automatic logic next_q(input logic j, input logic k, input logic q);
        jk_t op;
        op = {j, k};
        return op == JK_HOLD ? q :
               op == JK_CLR  ? 1'b0 :
               op == JK_SET  ? 1'b1 : ~q;
    endfunction

endpackage

// File: rtl/jkff_sar_if.sv
// jkff_sar_if: set/JK inputs and Q/QBAR outputs of the JK bank (CE present when JKFF_SAR_CE_EN is defined)
interface jkff_sar_if #(parameter int WIDTH = 1);

    logic             set;
`ifdef JKFF_SAR_CE_EN
    logic             ce;
`endif
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;

`ifdef JKFF_SAR_CE_EN
    modport master (output set, ce, j, k, input q, qbar);
    modport slave  (input set, ce, j, k, output q, qbar);
`else
    modport master (output set, j, k, input q, qbar);
    modport slave  (input set, j, k, output q, qbar);
`endif

endinterface

// File: rtl/jkff_sar_bit.sv
// jkff_sar_bit: single JK cell with async reset and async set (reset dominant)
module jkff_sar_bit
    import jkff_sar_pkg::*;
#(
    parameter logic SET_BIT = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic ce,
    input  logic j,
    input  logic k,
    output logic q
);

    // Set is masked by reset so that releasing reset while set is held
    // produces a rising edge here and loads the set value immediately.
    logic set_eff;
    assign set_eff = set & ~rst;

    // Async clear/set, otherwise JK update on enabled clock edges
    always_ff @(posedge clk or posedge rst or posedge set_eff)
        if (rst) q <= 1'b0;
        else if (set_eff) q <= SET_BIT;
        else if (ce) q <= next_q(j, k, q);

endmodule

// File: rtl/jkff_sar.sv
// jkff_sar: bank of WIDTH independent JK flip-flops with async reset/set; optional clock enable via JKFF_SAR_CE_EN
module jkff_sar
    import jkff_sar_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] SET_VALUE = '1
) (
    input logic       clk,
    input logic       rst,
    jkff_sar_if.slave bus
);

    logic             ce;
    logic [WIDTH-1:0] q;

`ifdef JKFF_SAR_CE_EN
    assign ce = bus.ce;
`else
    assign ce = 1'b1;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jkff_sar_bit #(.SET_BIT(SET_VALUE[i])) u_bit (
            .clk (clk),
            .rst (rst),
            .set (bus.set),
            .ce  (ce),
            .j   (bus.j[i]),
            .k   (bus.k[i]),
            .q   (q[i])
        );
    end

    assign bus.q    = q;
    assign bus.qbar = ~q;

endmodule

// File: tb/tb_jkff_sar.sv
// tb_jkff_sar: directed checks of the JK bank (1-bit and 4-bit instances)
module tb_jkff_sar;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    jkff_sar_if #(.WIDTH(1)) bus_a ();
    jkff_sar_if #(.WIDTH(4)) bus_b ();

    jkff_sar #(.WIDTH(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    jkff_sar #(.WIDTH(4), .SET_VALUE(4'b0101)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic exp);
        chk({tag, ".q"}, {7'd0, bus_a.q}, {7'd0, exp});
        chk({tag, ".qbar"}, {7'd0, bus_a.qbar}, {7'd0, ~exp});
    endtask

    task automatic chk_b(input string tag, input logic [3:0] exp);
        chk({tag, ".q"}, {4'd0, bus_b.q}, {4'd0, exp});
        chk({tag, ".qbar"}, {4'd0, bus_b.qbar}, {4'd0, ~exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] jk_seq [4];
        logic       tt_exp [4];
        logic       tog_exp [4];
        jk_seq  = '{2'b10, 2'b01, 2'b00, 2'b11};
        tt_exp  = '{1'b1, 1'b0, 1'b0, 1'b1};
        tog_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
        rst = 1'b1;
        bus_a.set = 1'b1;
        bus_a.j = 1'b0;
        bus_a.k = 1'b0;
        bus_b.set = 1'b0;
        bus_b.j = 4'd0;
        bus_b.k = 4'd0;
`ifdef JKFF_SAR_CE_EN
        bus_a.ce = 1'b1;
        bus_b.ce = 1'b1;
`endif
        // reset and set overlap, then staggered release
        #1 chk_a("rst_set_both", 1'b0);
        chk_b("b_reset", 4'b0000);
        #4 bus_a.set = 1'b0;
        #1 chk_a("set_released_in_rst", 1'b0);
        #2 rst = 1'b0;
        #1 chk_a("rst_released", 1'b0);
        tick();
        chk_a("hold_after_reset", 1'b0);
        // truth table
        for (int i = 0; i < 4; i++) begin
            {bus_a.j, bus_a.k} = jk_seq[i];
            tick();
            chk_a($sformatf("truth_jk%b", jk_seq[i]), tt_exp[i]);
        end
        // toggle run from 0
        {bus_a.j, bus_a.k} = 2'b01;
        tick();
        chk_a("clear_before_toggle", 1'b0);
        {bus_a.j, bus_a.k} = 2'b11;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_a($sformatf("toggle_%0d", i), tog_exp[i]);
        end
        // async set pulse between edges
        {bus_a.j, bus_a.k} = 2'b00;
        #3 bus_a.set = 1'b1;
        #1 chk_a("async_set", 1'b1);
        #2 bus_a.set = 1'b0;
        #1 chk_a("set_pulse_released", 1'b1);
        tick();
        chk_a("hold_after_set", 1'b1);
        // reset during set pulse
        {bus_a.j, bus_a.k} = 2'b01;
        tick();
        chk_a("clear_before_pulse", 1'b0);
        {bus_a.j, bus_a.k} = 2'b00;
        bus_a.set = 1'b1;
        #1 chk_a("set_pulse2", 1'b1);
        rst = 1'b1;
        #1 chk_a("rst_in_set_pulse", 1'b0);
        bus_a.set = 1'b0;
        #1 chk_a("set_drop_in_rst", 1'b0);
        rst = 1'b0;
        #1 chk_a("rst_drop_after_set", 1'b0);
        // releasing reset while set is held loads set value at once
        bus_a.set = 1'b1;
        rst = 1'b1;
        #1 chk_a("both_again", 1'b0);
        rst = 1'b0;
        #1 chk_a("rst_drop_set_held", 1'b1);
        bus_a.set = 1'b0;
        tick();
        chk_a("hold_after_set_release", 1'b1);
        // multi-bit independence
        bus_b.j = 4'b0011;
        bus_b.k = 4'b1100;
        tick();
        chk_b("b_load_0011", 4'b0011);
        bus_b.j = 4'b1010;
        bus_b.k = 4'b0110;
        tick();
        chk_b("b_mixed", 4'b1001);
        bus_b.j = 4'b0000;
        bus_b.k = 4'b0000;
        #3 bus_b.set = 1'b1;
        #1 chk_b("b_set_value", 4'b0101);
        bus_b.set = 1'b0;
        tick();
        chk_b("b_hold_set_value", 4'b0101);
`ifdef JKFF_SAR_CE_EN
        // clock enable gating
        {bus_a.j, bus_a.k} = 2'b01;
        tick();
        chk_a("ce_pre_clear", 1'b0);
        {bus_a.j, bus_a.k} = 2'b11;
        bus_a.ce = 1'b0;
        tick();
        chk_a("ce0_edge1", 1'b0);
        tick();
        chk_a("ce0_edge2", 1'b0);
        bus_a.ce = 1'b1;
        tick();
        chk_a("ce1_toggle", 1'b1);
        bus_a.ce = 1'b0;
        rst = 1'b1;
        #1 chk_a("rst_with_ce0", 1'b0);
        rst = 1'b0;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
